// File: rtl/mem_access_stage.sv
// mem_access_stage: load/store stage with a req/ack data bus; define MISALIGN_TRAP_EN to trap misaligned accesses.
`ifndef MEM_NONE
`define MEM_NONE 2'd0
`endif
`ifndef MEM_BYTE
`define MEM_BYTE 2'd1
`endif
`ifndef MEM_HALF
`define MEM_HALF 2'd2
`endif
`ifndef MEM_WORD
`define MEM_WORD 2'd3
`endif

module mem_access_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [1:0]  mem_access_width,
    input  logic        is_load_unsigned,
    input  logic        is_store,
    input  logic [4:0]  rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        out_misalign,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t      state_q, state_d;
    logic [31:0] out_data_q, out_data_d, dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic        out_we_q, out_we_d, out_misalign_q, out_misalign_d, dmem_we_q, dmem_we_d;
    logic [3:0]  dmem_be_q, dmem_be_d, be_st;
    logic [1:0]  off_q, off_d, width_q, width_d, off;
    logic        uns_q, uns_d, accept, is_mem, trap;
    logic [31:0] shifted, load_data, wd_st;

    assign accept = in_valid && in_ready;
    assign is_mem = mem_access_width != `MEM_NONE;
    // Lane offset with the bits a misaligned half/word cannot use forced to zero.
    assign off = mem_access_width == `MEM_WORD ? 2'b00 :
                 mem_access_width == `MEM_HALF ? {alu_result[1], 1'b0} : alu_result[1:0];
`ifdef MISALIGN_TRAP_EN
    assign trap = (mem_access_width == `MEM_HALF && alu_result[0]) ||
                  (mem_access_width == `MEM_WORD && alu_result[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif
    assign be_st = mem_access_width == `MEM_BYTE ? 4'b0001 << off :
                   mem_access_width == `MEM_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wd_st = mem_access_width == `MEM_BYTE ? {4{store_data[7:0]}} :
                   mem_access_width == `MEM_HALF ? {2{store_data[15:0]}} : store_data;
    assign shifted = dmem_rdata >> {off_q, 3'b000};
    assign load_data = width_q == `MEM_BYTE ? {{24{shifted[7] & ~uns_q}}, shifted[7:0]} :
                       width_q == `MEM_HALF ? {{16{shifted[15] & ~uns_q}}, shifted[15:0]} : shifted;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            out_data_q     <= '0;
            out_rd_q       <= '0;
            out_we_q       <= 1'b0;
            out_misalign_q <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_we_q      <= 1'b0;
            dmem_be_q      <= '0;
            dmem_wdata_q   <= '0;
            off_q          <= '0;
            width_q        <= '0;
            uns_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            out_data_q     <= out_data_d;
            out_rd_q       <= out_rd_d;
            out_we_q       <= out_we_d;
            out_misalign_q <= out_misalign_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_we_q      <= dmem_we_d;
            dmem_be_q      <= dmem_be_d;
            dmem_wdata_q   <= dmem_wdata_d;
            off_q          <= off_d;
            width_q        <= width_d;
            uns_q          <= uns_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && accept)
            state_d = (is_mem && !trap) ? BUS : RESP;
        else if (state_q == BUS && dmem_ack)
            state_d = RESP;
        else if (state_q == RESP && out_ready)
            state_d = IDLE;
    end

    always_comb begin
        out_data_d     = out_data_q;
        out_rd_d       = out_rd_q;
        out_we_d       = out_we_q;
        out_misalign_d = out_misalign_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_we_d      = dmem_we_q;
        dmem_be_d      = dmem_be_q;
        dmem_wdata_d   = dmem_wdata_q;
        off_d          = off_q;
        width_d        = width_q;
        uns_d          = uns_q;
        if (accept) begin
            out_data_d     = alu_result;
            out_rd_d       = rd;
            out_we_d       = !is_store && rd != 5'd0 && !trap;
            out_misalign_d = trap;
            if (is_mem && !trap) begin
                dmem_addr_d  = {alu_result[31:2], 2'b00};
                dmem_we_d    = is_store;
                dmem_be_d    = be_st;
                dmem_wdata_d = wd_st;
                off_d        = off;
                width_d      = mem_access_width;
                uns_d        = is_load_unsigned;
            end
        end else if (state_q == BUS && dmem_ack && !dmem_we_q) begin
            out_data_d = load_data;
        end
    end

    always_comb begin
        in_ready     = rst_n && state_q == IDLE;
        out_valid    = state_q == RESP;
        dmem_req     = state_q == BUS;
        out_data     = out_data_q;
        out_rd       = out_rd_q;
        out_we       = out_we_q;
        out_misalign = out_misalign_q;
        dmem_we      = dmem_we_q;
        dmem_addr    = dmem_addr_q;
        dmem_be      = dmem_be_q;
        dmem_wdata   = dmem_wdata_q;
    end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Clock and reset: one clock, clk; reset rst_n, synchronous, active-low; all state updates on rising clk edge.
REQ-002 Ports, as name / direction / width / meaning:
- clk  in  1  clock
- rst_n  in  1  sync active-low reset
- in_valid  in  1  execute-stage result valid
- in_ready  out  1  stage can accept
- alu_result  in  32  effective address, or ALU result for non-memory ops
- store_data  in  32  rs2 value for stores
- mem_access_width  in  2  `MEM_NONE/`MEM_BYTE/`MEM_HALF/`MEM_WORD (define.svh)
- is_load_unsigned  in  1  zero-extend load
- is_store  in  1  store op
- rd  in  5  destination register
- out_valid  out  1  writeback result valid
- out_ready  in  1  writeback accepts
- out_data  out  32  load data / ALU result / faulting address
- out_rd  out  5  destination register
- out_we  out  1  register write enable
- out_misalign  out  1  misaligned access flag
- dmem_req  out  1  bus request
- dmem_we  out  1  bus write
- dmem_addr  out  32  word-aligned address
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  write data
- dmem_ack  in  1  bus completion
- dmem_rdata  in  32  read data, valid with dmem_ack

Function
REQ-003 FSM states: IDLE, BUS, RESP.
REQ-004 in_ready SHALL be 1 only in IDLE with rst_n high; input is accepted on in_valid && in_ready.
REQ-005 Accepted op with `MEM_NONE SHALL go IDLE->RESP; out_data=alu_result; out_valid asserts the next cycle.
REQ-006 Accepted load/store SHALL go IDLE->BUS and raise dmem_req the next cycle; dmem_addr={alu_result[31:2],2'b00}; dmem_we=is_store.
REQ-007 dmem_req, addr, we, be and wdata SHALL hold stable in BUS until dmem_ack; on ack, BUS->RESP and dmem_req drops the next cycle.
REQ-008 Byte lane encoding:
- byte: be=1<<addr[1:0], wdata=store_data[7:0] replicated x4
- half: be=addr[1]?4'b1100:4'b0011, wdata=store_data[15:0] replicated x2
- word: be=4'b1111, wdata=store_data
REQ-009 Load data SHALL be captured on dmem_ack, shifted right by 8*addr[1:0], and then sign-extended to 32 bits, or zero-extended when is_load_unsigned=1.
REQ-010 In RESP, out_valid=1; outputs SHALL be held until out_ready; on out_valid&&out_ready, RESP->IDLE.
REQ-011 Zero-bubble back-to-back acceptance is not required; minimum accept spacing is 2 cycles for non-memory ops and 3 cycles for memory ops with ack in the first BUS cycle.
REQ-012 out_we SHALL equal !is_store && rd!=0 && !out_misalign; stores SHALL produce a RESP beat with out_we=0 and out_data=alu_result.
REQ-013 dmem_ack outside BUS SHALL be ignored.
REQ-014 is_load_unsigned SHALL be ignored for stores and for `MEM_NONE.

Reset
REQ-015 rst_n low at a clock edge SHALL force IDLE, including from BUS or RESP; any pending op is discarded.
REQ-016 Reset values: out_valid=0, dmem_req=0, dmem_we=0, dmem_be=0, out_we=0, out_misalign=0, out_data=0, out_rd=0, dmem_addr=0, dmem_wdata=0.
REQ-017 An ack arriving after reset aborted a BUS transaction SHALL have no effect.

Configuration
REQ-018 Macro MISALIGN_TRAP_EN selects misalignment handling:
- Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
- Defined: a misaligned access SHALL NOT enter BUS; IDLE->RESP with out_misalign=1, out_we=0, out_data=alu_result.
- Undefined: the offending low address bits are treated as 0; out_misalign is tied 0.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- LW at 0x100, ack after 3 cycles with rdata=0xDEADBEEF -> dmem_addr=0x100, be=1111, req held for 3 cycles, out_data=0xDEADBEEF, out_we=1.
- LB at 0x203, rdata=0x80xxxxxx -> be=1000, out_data=0xFFFFFF80; same access as LBU -> out_data=0x00000080.
- SH at 0x302 with store_data=0x1234ABCD -> dmem_we=1, be=1100, wdata=0xABCDABCD, out_we=0.
- MEM_NONE, alu_result=7, rd=5, out_ready held low for 4 cycles -> out_valid and out_data held, in_ready=0, one beat delivered on release.
- LW at 0x101 -> with MISALIGN_TRAP_EN: no dmem_req, out_misalign=1, out_data=0x101; without: addr=0x100, be=1111.
- rst_n low during BUS, then a stray ack -> dmem_req=0 after the edge, state IDLE, no out_valid.
